// File: rtl/prbs9_tx.sv
// rtl/prbs9_tx.sv - PRBS9 (x^9+x^5+1) bit source with oversampled valid strobe and error injection
module prbs9_tx #(
    parameter logic [8:0] SEED      = 9'h1FF,
    parameter int         OS_FACTOR = 4,
    parameter int         REG_LEN   = 64,
    parameter int         PER_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               seed_load,
    input  logic [8:0]         seed_in,
    input  logic               inject_err,
    input  logic [PER_W-1:0]   inject_period,
    output logic               valid,
    output logic               bit_out,
    output logic               ref_bit,
    output logic               seq_start,
    output logic [REG_LEN-1:0] bit_count,
    output logic [REG_LEN-1:0] inj_count
);

    localparam int              PH_W    = (OS_FACTOR > 2) ? $clog2(OS_FACTOR) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_FACTOR - 1);

    logic [8:0]         lfsr_q, lfsr_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               pend_q, pend_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               valid_q, valid_d;
    logic               bit_out_q, bit_out_d;
    logic               ref_bit_q, ref_bit_d;
    logic               seq_start_q, seq_start_d;
    logic [REG_LEN-1:0] bit_count_q, bit_count_d;
    logic [REG_LEN-1:0] inj_count_q, inj_count_d;

    logic emit;
    logic per_hit;
    logic flip;

    always_comb begin
        emit    = enable && (phase_q == PH_LAST);
        per_hit = (inject_period != '0) && (per_cnt_q == inject_period - PER_W'(1));
        flip    = pend_q | per_hit;

        lfsr_d      = lfsr_q;
        phase_d     = phase_q;
        pend_d      = pend_q;
        per_cnt_d   = per_cnt_q;
        period_d    = inject_period;
        valid_d     = 1'b0;
        bit_out_d   = bit_out_q;
        ref_bit_d   = ref_bit_q;
        seq_start_d = 1'b0;
        bit_count_d = bit_count_q;
        inj_count_d = inj_count_q;

        if (seed_load) begin
            // A zero seed would lock the LFSR, so substitute the default.
            lfsr_d      = (seed_in == 9'd0) ? SEED : seed_in;
            phase_d     = '0;
            pend_d      = 1'b0;
            per_cnt_d   = '0;
            bit_count_d = '0;
            inj_count_d = '0;
        end else begin
            if (enable) begin
                phase_d = emit ? '0 : phase_q + PH_W'(1);
            end

            // A pulse on the emit edge itself is kept for the following bit.
            pend_d = inject_err | (pend_q & ~emit);

            if ((inject_period != period_q) || (inject_period == '0)) begin
                per_cnt_d = '0;
            end else if (emit) begin
                per_cnt_d = per_hit ? '0 : per_cnt_q + PER_W'(1);
            end

            if (emit) begin
                ref_bit_d   = lfsr_q[8];
                bit_out_d   = lfsr_q[8] ^ flip;
                valid_d     = 1'b1;
                seq_start_d = (lfsr_q == SEED);
                lfsr_d      = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
                bit_count_d = bit_count_q + REG_LEN'(1);
                inj_count_d = inj_count_q + REG_LEN'(flip);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q      <= SEED;
            phase_q     <= '0;
            pend_q      <= 1'b0;
            per_cnt_q   <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            bit_out_q   <= 1'b0;
            ref_bit_q   <= 1'b0;
            seq_start_q <= 1'b0;
            bit_count_q <= '0;
            inj_count_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            per_cnt_q   <= per_cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            bit_out_q   <= bit_out_d;
            ref_bit_q   <= ref_bit_d;
            seq_start_q <= seq_start_d;
            bit_count_q <= bit_count_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign valid     = valid_q;
    assign bit_out   = bit_out_q;
    assign ref_bit   = ref_bit_q;
    assign seq_start = seq_start_q;
    assign bit_count = bit_count_q;
    assign inj_count = inj_count_q;

endmodule

// File: tb/tb_prbs9_tx.sv
// tb/tb_prbs9_tx.sv - directed self-checking bench for prbs9_tx
module tb_prbs9_tx;

    localparam int OS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [8:0]  seed_in = 9'd0;
    logic        inject_err = 1'b0;
    logic [15:0] inject_period = 16'd0;
    logic        valid, bit_out, ref_bit, seq_start;
    logic [63:0] bit_count, inj_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [8:0] m_lfsr;

    localparam logic [9:0] T1_BITS = 10'b1111111110;
    localparam logic [9:0] T1_SEQ  = 10'b1000000000;

    prbs9_tx #(.SEED(9'h1FF), .OS_FACTOR(OS), .REG_LEN(64), .PER_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
        .inject_err(inject_err), .inject_period(inject_period), .valid(valid),
        .bit_out(bit_out), .ref_bit(ref_bit), .seq_start(seq_start),
        .bit_count(bit_count), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && dut.lfsr_q == 9'd0) begin
            n_fail++;
            $display("FAIL lfsr_zero: lfsr reached 0");
        end
    end

    function automatic logic [8:0] nxt(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int i = 0; i < 2 * OS; i++) begin
            @(negedge clk);
            if (valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Assumes the first valid is being observed right now.
    task automatic collect10(output logic [9:0] bits, output logic [9:0] seqs, output bit to);
        bit t;
        to = 1'b0;
        bits[9] = bit_out;
        seqs[9] = seq_start;
        for (int k = 8; k >= 0; k--) begin
            wait_valid(t);
            to |= t;
            bits[k] = bit_out;
            seqs[k] = seq_start;
        end
    endtask

    task automatic do_seed_load(input logic [8:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] vpat;
        logic [9:0] bits, seqs;
        bit to;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({valid, bit_out, ref_bit, seq_start, bit_count, inj_count} !== '0)
            begin n_fail++; $display("FAIL reset_state: got v=%b b=%b r=%b s=%b bc=%0d ic=%0d want all 0",
                valid, bit_out, ref_bit, seq_start, bit_count, inj_count); end
        rst = 1'b1;
        for (int c = 3; c >= 0; c--) begin
            @(negedge clk);
            vpat[c] = valid;
        end
        n_cmp++;
        if (vpat !== 4'b0001) begin n_fail++; $display("FAIL first_valid: got %b want 0001", vpat); end
        collect10(bits, seqs, to);
        n_cmp++;
        if (to || bits !== T1_BITS) begin n_fail++; $display("FAIL t1_bits: got %b to=%0d want %b", bits, to, T1_BITS); end
        n_cmp++;
        if (seqs !== T1_SEQ) begin n_fail++; $display("FAIL t1_seq: got %b want %b", seqs, T1_SEQ); end
        n_cmp++;
        if (bit_count !== 64'd10) begin n_fail++; $display("FAIL t1_count: got %0d want 10", bit_count); end
    endtask

    task automatic test_free_run();
        int e_bit = 0, e_ref = 0, e_seq = 0, e_to = 0;
        bit to;
        do_seed_load(9'h1FF);
        m_lfsr = 9'h1FF;
        for (int i = 0; i < 1022; i++) begin
            wait_valid(to);
            if (to) e_to++;
            if (bit_out !== m_lfsr[8]) e_bit++;
            if (ref_bit !== bit_out) e_ref++;
            if (seq_start !== (i == 0 || i == 511)) e_seq++;
            m_lfsr = nxt(m_lfsr);
        end
        n_cmp++;
        if (e_to != 0 || e_bit != 0) begin n_fail++; $display("FAIL run_bits: got %0d bit errs %0d timeouts want 0", e_bit, e_to); end
        n_cmp++;
        if (e_ref != 0) begin n_fail++; $display("FAIL run_ref: got %0d bit/ref diffs want 0", e_ref); end
        n_cmp++;
        if (e_seq != 0) begin n_fail++; $display("FAIL run_seq: got %0d seq_start errs want 0", e_seq); end
        n_cmp++;
        if (bit_count !== 64'd1022 || inj_count !== 64'd0)
            begin n_fail++; $display("FAIL run_count: got bc=%0d ic=%0d want 1022/0", bit_count, inj_count); end
    endtask

    task automatic test_inject();
        int e_bit = 0, e_ref = 0;
        bit to;
        do_seed_load(9'h1FF);
        m_lfsr = 9'h1FF;
        for (int i = 1; i <= 14; i++) begin
            wait_valid(to);
            if (to) e_bit++;
            inject_err = 1'b0;
            if (bit_out !== (m_lfsr[8] ^ (i == 11 || i == 14))) e_bit++;
            if (ref_bit !== m_lfsr[8]) e_ref++;
            m_lfsr = nxt(m_lfsr);
            if (i == 10) begin
                inject_err = 1'b1;
                @(negedge clk); inject_err = 1'b0;
                @(negedge clk); inject_err = 1'b1;
                @(negedge clk); inject_err = 1'b0;
            end else if (i == 12) begin
                // Pulse lands on the emit edge of bit 13, so bit 14 takes it.
                repeat (3) @(negedge clk);
                inject_err = 1'b1;
            end
        end
        n_cmp++;
        if (e_bit != 0) begin n_fail++; $display("FAIL inj_bits: got %0d errs want 0", e_bit); end
        n_cmp++;
        if (e_ref != 0) begin n_fail++; $display("FAIL inj_ref: got %0d errs want 0", e_ref); end
        n_cmp++;
        if (inj_count !== 64'd2 || bit_count !== 64'd14)
            begin n_fail++; $display("FAIL inj_count: got ic=%0d bc=%0d want 2/14", inj_count, bit_count); end
    endtask

    task automatic test_period();
        int e_bit = 0;
        bit to;
        inject_period = 16'd100;
        do_seed_load(9'h1FF);
        m_lfsr = 9'h1FF;
        for (int i = 1; i <= 1000; i++) begin
            wait_valid(to);
            if (to) e_bit++;
            if (bit_out !== (m_lfsr[8] ^ (i % 100 == 0))) e_bit++;
            m_lfsr = nxt(m_lfsr);
            if (i == 299) begin
                inject_err = 1'b1;
                @(negedge clk);
                inject_err = 1'b0;
            end
        end
        n_cmp++;
        if (e_bit != 0) begin n_fail++; $display("FAIL per100_bits: got %0d errs want 0", e_bit); end
        n_cmp++;
        if (inj_count !== 64'd10 || bit_count !== 64'd1000)
            begin n_fail++; $display("FAIL per100_count: got ic=%0d bc=%0d want 10/1000", inj_count, bit_count); end

        e_bit = 0;
        inject_period = 16'd1;
        do_seed_load(9'h1FF);
        m_lfsr = 9'h1FF;
        for (int i = 1; i <= 5; i++) begin
            wait_valid(to);
            if (to || bit_out !== ~m_lfsr[8]) e_bit++;
            m_lfsr = nxt(m_lfsr);
        end
        inject_period = 16'd0;
        n_cmp++;
        if (e_bit != 0 || inj_count !== 64'd5)
            begin n_fail++; $display("FAIL per1: got %0d errs ic=%0d want 0/5", e_bit, inj_count); end
    endtask

    task automatic test_enable();
        int vcount = 0;
        bit to;
        enable = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid) vcount++;
            inject_err = (c == 4);
        end
        inject_err = 1'b0;
        n_cmp++;
        if (vcount != 0 || bit_count !== 64'd5)
            begin n_fail++; $display("FAIL freeze: got %0d valids bc=%0d want 0/5", vcount, bit_count); end
        enable = 1'b1;
        wait_valid(to);
        n_cmp++;
        if (to || bit_out !== ~m_lfsr[8] || ref_bit !== m_lfsr[8] || inj_count !== 64'd6)
            begin n_fail++; $display("FAIL resume_inject: got b=%b r=%b ic=%0d to=%0d want %b/%b/6",
                bit_out, ref_bit, inj_count, to, ~m_lfsr[8], m_lfsr[8]); end
        m_lfsr = nxt(m_lfsr);
    endtask

    task automatic test_seed_zero();
        logic [9:0] bits, seqs;
        int cnt = 0;
        bit to;
        repeat (3) wait_valid(to);
        @(negedge clk);
        do_seed_load(9'd0);
        n_cmp++;
        if (bit_count !== 64'd0 || inj_count !== 64'd0 || valid !== 1'b0)
            begin n_fail++; $display("FAIL seed0_clear: got bc=%0d ic=%0d v=%b want 0/0/0", bit_count, inj_count, valid); end
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 8);
        n_cmp++;
        if (cnt != OS) begin n_fail++; $display("FAIL seed0_latency: got %0d want %0d", cnt, OS); end
        collect10(bits, seqs, to);
        n_cmp++;
        if (to || bits !== T1_BITS || seqs !== T1_SEQ)
            begin n_fail++; $display("FAIL seed0_bits: got %b/%b want %b/%b", bits, seqs, T1_BITS, T1_SEQ); end
    endtask

    task automatic test_async_reset();
        logic [3:0] vpat;
        logic [9:0] bits, seqs;
        bit to;
        do_seed_load(9'h1FF);
        repeat (3) wait_valid(to);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({valid, bit_out, ref_bit, seq_start, bit_count, inj_count} !== '0)
            begin n_fail++; $display("FAIL async_reset: got b=%b r=%b bc=%0d want all 0", bit_out, ref_bit, bit_count); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 3; c >= 0; c--) begin
            @(negedge clk);
            vpat[c] = valid;
        end
        n_cmp++;
        if (vpat !== 4'b0001) begin n_fail++; $display("FAIL rst_first_valid: got %b want 0001", vpat); end
        collect10(bits, seqs, to);
        n_cmp++;
        if (to || bits !== T1_BITS || seqs !== T1_SEQ)
            begin n_fail++; $display("FAIL rst_bits: got %b/%b want %b/%b", bits, seqs, T1_BITS, T1_SEQ); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_inject();
        test_period();
        test_enable();
        test_seed_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
